gene_segment_reader: RTL and testbench
======================================

GENE_SEGMENT_READER -- requirements
Module: gene_segment_reader

Interface
REQ-001 The block SHALL have parameter ELEMENT_SIZE, default 4, giving the bits per gene element.
REQ-002 The block SHALL have parameter ELEMENT_COUNT, default 32, giving the new elements per segment.
REQ-003 The block SHALL have parameter CODON_MAX_LENGTH, default 5; the overlap between segments is CODON_MAX_LENGTH-1.
REQ-004 The block SHALL have parameter GENE_MEM_DEPTH, default 256 (elements); it must be a multiple of ELEMENT_COUNT.
REQ-005 The block SHALL have derived localparams:
- SEGMENT_SIZE = ELEMENT_COUNT+CODON_MAX_LENGTH-1 (36);
- SEG_COUNT = GENE_MEM_DEPTH/ELEMENT_COUNT (8);
- AW = clog2(GENE_MEM_DEPTH);
- IW = max(1, clog2(SEG_COUNT)).
REQ-006 The block SHALL have one clock and an asynchronous active-low reset, with ports:
- CLK  in  1  rising-edge clock;
- RST_N  in  1  asynchronous active-low reset.
REQ-007 The control ports SHALL be:
- START  in  1  one-cycle pulse that begins a full pass;
- BUSY  out  1  high while a pass is in progress;
- DONE  out  1  one-cycle pulse after the last segment is accepted.
REQ-008 The memory ports SHALL be:
- MEM_EN  out  1  read enable;
- MEM_ADDR  out  AW  element address;
- MEM_RDATA  in  ELEMENT_SIZE  read data, valid exactly 1 cycle after MEM_EN.
REQ-009 The segment ports SHALL be:
- SEG_VALID  out  1;
- SEG_READY  in  1;
- SEG_DATA  out  SEGMENT_SIZE*ELEMENT_SIZE;
- SEG_IDX  out  IW;
- SEG_LAST  out  1.

Function
REQ-010 Segment k SHALL hold elements at addresses k*ELEMENT_COUNT+j, for j = 0..SEGMENT_SIZE-1, with element j at SEG_DATA[j*ELEMENT_SIZE +: ELEMENT_SIZE].
REQ-011 Any element whose address is >= GENE_MEM_DEPTH SHALL be zero-filled, and no memory read SHALL be issued for it.
REQ-012 The FSM SHALL have the states IDLE, FETCH, DRAIN and PRESENT.
REQ-013 In IDLE, START=1 SHALL move the FSM to FETCH with segment index 0; START SHALL be ignored in every other state.
REQ-014 FETCH SHALL last exactly SEGMENT_SIZE cycles and issue offset j in its j-th cycle, with MEM_EN=1 only for in-range addresses; it then moves to DRAIN.
REQ-015 DRAIN SHALL last 1 cycle, capturing the last read, and then move to PRESENT.
REQ-016 Each MEM_RDATA value SHALL be captured into element slot j on the cycle after its issue.
REQ-017 In PRESENT, SEG_VALID SHALL be 1.
REQ-018 SEG_DATA, SEG_IDX and SEG_LAST SHALL stay stable while SEG_VALID=1 and SEG_READY=0.
REQ-019 A transfer SHALL occur on a rising edge with SEG_VALID=1 and SEG_READY=1. If SEG_IDX < SEG_COUNT-1, the index increments and the FSM returns to FETCH on the next cycle.
REQ-020 On the transfer of segment SEG_COUNT-1:
- DONE=1 on the next cycle, for exactly one cycle;
- the FSM goes to IDLE.
REQ-021 SEG_LAST SHALL equal (SEG_IDX == SEG_COUNT-1) while SEG_VALID=1, and 0 otherwise.
REQ-022 BUSY SHALL be 1 in FETCH, DRAIN and PRESENT, and 0 in IDLE.
REQ-023 SEG_READY asserted before SEG_VALID SHALL have no effect.
REQ-024 Latency: with START sampled at edge 0, MEM_EN SHALL first be high in cycle 1, and SEG_VALID SHALL first be high in cycle SEGMENT_SIZE+2 (38).
REQ-025 With SEG_READY held at 1, successive segments SHALL start SEGMENT_SIZE+2 cycles apart.
REQ-026 Addresses SHALL never exceed GENE_MEM_DEPTH-1; the address counter SHALL not wrap.

Reset
REQ-027 RST_N=0 SHALL immediately, asynchronously, force:
- the FSM to IDLE;
- BUSY, DONE, MEM_EN, SEG_VALID and SEG_LAST to 0;
- MEM_ADDR, SEG_IDX and SEG_DATA to 0.
REQ-028 Reset asserted mid-pass SHALL discard the partial segment; a pass after release SHALL restart at segment 0 only on a new START.
REQ-029 Reset deassertion SHALL take effect on the next rising CLK, with no output glitch.

Verification
REQ-030 Single pass: memory holds addr[3:0] at each address; START pulse; SEG_READY=1.
- Required: 8 segments, SEG_IDX 0..7.
- Segment 0 element j = j mod 16.
- SEG_VALID first at cycle 38; DONE 1 cycle after the segment-7 transfer.
REQ-031 Tail padding: in segment 7, elements 32..35 SHALL be 0, and MEM_EN SHALL never be high with MEM_ADDR > 255.
REQ-032 Backpressure: hold SEG_READY=0 for 10 cycles on segment 2.
- Required: SEG_VALID, SEG_DATA and SEG_IDX held constant.
- No memory reads during the hold.
- Segment 3 fetch begins 1 cycle after the transfer.
REQ-033 START while BUSY: pulse START at cycle 50. Required: no change to the sequence, SEG_IDX or the DONE timing.
REQ-034 Mid-pass reset: pull RST_N low during FETCH of segment 4.
- Required: all outputs 0 at once.
- A new START yields SEG_IDX=0 with correct data.
REQ-035 Overlap check: with random memory contents, for every k<7, elements 32..35 of segment k SHALL equal elements 0..3 of segment k+1.

Source files
------------

// File: rtl/gene_segment_reader.sv
// Streams a gene memory out as overlapping segments: each segment carries ELEMENT_COUNT new
// elements plus CODON_MAX_LENGTH-1 look-ahead elements, zero-padded past the end of memory.
module gene_segment_reader #(
    parameter int ELEMENT_SIZE     = 4,
    parameter int ELEMENT_COUNT    = 32,
    parameter int CODON_MAX_LENGTH = 5,
    parameter int GENE_MEM_DEPTH   = 256,
    localparam int SEGMENT_SIZE    = ELEMENT_COUNT + CODON_MAX_LENGTH - 1,
    localparam int SEG_COUNT       = GENE_MEM_DEPTH / ELEMENT_COUNT,
    localparam int AW              = $clog2(GENE_MEM_DEPTH),
    localparam int IW              = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1
) (
    input  logic                             CLK,
    input  logic                             RST_N,
    input  logic                             START,
    output logic                             BUSY,
    output logic                             DONE,
    output logic                             MEM_EN,
    output logic [AW-1:0]                    MEM_ADDR,
    input  logic [ELEMENT_SIZE-1:0]          MEM_RDATA,
    output logic                             SEG_VALID,
    input  logic                             SEG_READY,
    output logic [SEGMENT_SIZE*ELEMENT_SIZE-1:0] SEG_DATA,
    output logic [IW-1:0]                    SEG_IDX,
    output logic                             SEG_LAST,
    output logic [1:0]                       dbg_state
);
    // Segment handshake: a segment transfers on any rising CLK where SEG_VALID and SEG_READY
    // are both 1; SEG_DATA/SEG_IDX/SEG_LAST hold steady while SEG_VALID=1 and SEG_READY=0.
    localparam int OW = (SEGMENT_SIZE > 1) ? $clog2(SEGMENT_SIZE) : 1;
    localparam int FW = $clog2(GENE_MEM_DEPTH + SEGMENT_SIZE) + 1;
    localparam int DW = SEGMENT_SIZE * ELEMENT_SIZE;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, PRESENT = 2'd3} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [OW-1:0]   off_q, off_d;
    logic            cap_en_q, cap_en_d;
    logic [OW-1:0]   cap_slot_q, cap_slot_d;
    logic            cap_inr_q, cap_inr_d;
    logic [DW-1:0]   seg_data_q, seg_data_d;
    logic            done_q, done_d;

    logic [FW-1:0]   full_addr;
    logic            in_range;
    logic            fetch_end;
    logic            is_last;
    logic            xfer;

    assign full_addr = FW'(idx_q) * FW'(ELEMENT_COUNT) + FW'(off_q);
    assign in_range  = full_addr < FW'(GENE_MEM_DEPTH);
    assign fetch_end = off_q == OW'(SEGMENT_SIZE - 1);
    assign is_last   = idx_q == IW'(SEG_COUNT - 1);
    assign xfer      = (state_q == PRESENT) && SEG_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            off_q      <= '0;
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            cap_inr_q  <= 1'b0;
            seg_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            off_q      <= off_d;
            cap_en_q   <= cap_en_d;
            cap_slot_q <= cap_slot_d;
            cap_inr_q  <= cap_inr_d;
            seg_data_q <= seg_data_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = FETCH;
            FETCH:   if (fetch_end) state_d = DRAIN;
            DRAIN:   state_d = PRESENT;
            PRESENT: if (SEG_READY) state_d = is_last ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Read data returns one cycle after issue, so each capture is tagged with the slot and
    // whether a real read was made; out-of-range slots are filled with zero instead.
    always_comb begin
        idx_d = idx_q;
        if (state_q == IDLE && START) begin
            idx_d = '0;
        end else if (xfer && !is_last) begin
            idx_d = idx_q + 1'b1;
        end
        off_d      = (state_q == FETCH && !fetch_end) ? off_q + 1'b1 : '0;
        cap_en_d   = (state_q == FETCH);
        cap_slot_d = off_q;
        cap_inr_d  = in_range;
        seg_data_d = seg_data_q;
        if (cap_en_q) begin
            seg_data_d[int'(cap_slot_q) * ELEMENT_SIZE +: ELEMENT_SIZE] =
                cap_inr_q ? MEM_RDATA : '0;
        end
        done_d = xfer && is_last;
    end

    always_comb begin
        BUSY      = (state_q != IDLE);
        MEM_EN    = (state_q == FETCH) && in_range;
        MEM_ADDR  = MEM_EN ? full_addr[AW-1:0] : '0;
        SEG_VALID = (state_q == PRESENT);
        SEG_LAST  = (state_q == PRESENT) && is_last;
        SEG_DATA  = seg_data_q;
        SEG_IDX   = idx_q;
        DONE      = done_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_gene_segment_reader.sv
// Directed bench for gene_segment_reader: full pass, backpressure with overlap check,
// START while busy, and mid-pass reset with restart.
module tb_gene_segment_reader;
  localparam int ES    = 4;
  localparam int EC    = 32;
  localparam int SEGSZ = 36;
  localparam int DEPTH = 256;
  localparam int SW    = SEGSZ * ES;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic          BUSY;
  logic          DONE;
  logic          MEM_EN;
  logic [7:0]    MEM_ADDR;
  logic [ES-1:0] MEM_RDATA;
  logic          SEG_VALID;
  logic          SEG_READY;
  logic [SW-1:0] SEG_DATA;
  logic [2:0]    SEG_IDX;
  logic          SEG_LAST;
  logic [1:0]    dbg_state;

  gene_segment_reader dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
    .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .SEG_VALID(SEG_VALID), .SEG_READY(SEG_READY), .SEG_DATA(SEG_DATA),
    .SEG_IDX(SEG_IDX), .SEG_LAST(SEG_LAST), .dbg_state(dbg_state)
  );

  // clock / memory model
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [ES-1:0] mem [0:DEPTH-1];
  int rd_cnt = 0;
  always @(posedge CLK) begin
    if (MEM_EN) begin
      MEM_RDATA <= mem[MEM_ADDR];
      rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_busy_cyc = -1;
  logic [SW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] exp_seg(input int k);
    logic [SW-1:0] s;
    s = '0;
    for (int j = 0; j < SEGSZ; j++) begin
      if (k * EC + j < DEPTH) s[j*ES +: ES] = mem[k*EC + j];
    end
    return s;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    START = (cyc == start_busy_cyc) ? 1'b1 : 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!SEG_VALID && n < 200) begin
      tick();
      n++;
    end
    check(tag, 160'(SEG_VALID), 160'(1));
  endtask

  task automatic begin_pass();
    START = 1'b1;
    cyc = 0;
    tick();
  endtask

  logic [SW-1:0] prev_seg;
  logic [SW-1:0] snap;
  int rd_base;

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    SEG_READY = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'(i);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 160'(BUSY), 160'(0));
    check("rst_done", 160'(DONE), 160'(0));
    check("rst_mem_en", 160'(MEM_EN), 160'(0));
    check("rst_valid", 160'(SEG_VALID), 160'(0));
    check("rst_last", 160'(SEG_LAST), 160'(0));
    check("rst_addr", 160'(MEM_ADDR), 160'(0));
    check("rst_idx", 160'(SEG_IDX), 160'(0));
    check("rst_data", 160'(SEG_DATA), 160'(0));
    check("rst_state", 160'(dbg_state), 160'(0));
    RST_N = 1'b1;
    tick();
    tick();
    check("idle_busy", 160'(BUSY), 160'(0));

    // pass 1: address-pattern memory, READY held high, stray START at cycle 50
    SEG_READY = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_seg(k));
    rd_base = rd_cnt;
    start_busy_cyc = 50;
    begin_pass();
    check("c1_mem_en", 160'(MEM_EN), 160'(1));
    check("c1_addr", 160'(MEM_ADDR), 160'(0));
    check("c1_busy", 160'(BUSY), 160'(1));
    check("c1_state", 160'(dbg_state), 160'(1));
    for (int k = 0; k < 8; k++) begin
      wait_valid("p1_valid");
      check("p1_valid_cycle", 160'(cyc), 160'(38 + 38 * k));
      check("p1_idx", 160'(SEG_IDX), 160'(k));
      check("p1_last", 160'(SEG_LAST), 160'(k == 7));
      check("p1_data", 160'(SEG_DATA), 160'(exp_q.pop_front()));
      if (k == 0) check("p1_seg0_e17", 160'(SEG_DATA[17*ES +: ES]), 160'(1));
      if (k == 7) check("p1_tail_zero", 160'(SEG_DATA[32*ES +: 4*ES]), 160'(0));
      tick();
      if (k < 7) begin
        check("p1_next_valid", 160'(SEG_VALID), 160'(0));
        check("p1_next_addr", 160'(MEM_ADDR), 160'((k + 1) * EC));
        check("p1_no_done", 160'(DONE), 160'(0));
      end else begin
        check("p1_done", 160'(DONE), 160'(1));
        check("p1_done_cycle", 160'(cyc), 160'(305));
        check("p1_idle", 160'(BUSY), 160'(0));
        check("p1_last_off", 160'(SEG_LAST), 160'(0));
      end
    end
    tick();
    check("p1_done_pulse", 160'(DONE), 160'(0));
    check("p1_read_count", 160'(rd_cnt - rd_base), 160'(284));
    start_busy_cyc = -1;

    // pass 2: random memory, accept on demand, hold segment 2 for 10 cycles
    for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_seg(k));
    SEG_READY = 1'b0;
    tick();
    begin_pass();
    for (int k = 0; k < 8; k++) begin
      wait_valid("p2_valid");
      check("p2_idx", 160'(SEG_IDX), 160'(k));
      check("p2_data", 160'(SEG_DATA), 160'(exp_q.pop_front()));
      if (k > 0) check("p2_overlap", 160'(SEG_DATA[0 +: 4*ES]), 160'(prev_seg[32*ES +: 4*ES]));
      prev_seg = SEG_DATA;
      if (k == 2) begin
        snap = SEG_DATA;
        rd_base = rd_cnt;
        for (int h = 0; h < 10; h++) begin
          tick();
          check("hold_valid", 160'(SEG_VALID), 160'(1));
          check("hold_data", 160'(SEG_DATA), 160'(snap));
          check("hold_idx", 160'(SEG_IDX), 160'(2));
          check("hold_mem_en", 160'(MEM_EN), 160'(0));
        end
        check("hold_reads", 160'(rd_cnt - rd_base), 160'(0));
      end
      SEG_READY = 1'b1;
      tick();
      SEG_READY = 1'b0;
      if (k == 2) begin
        check("p2_seg3_mem_en", 160'(MEM_EN), 160'(1));
        check("p2_seg3_addr", 160'(MEM_ADDR), 160'(96));
      end
      if (k == 7) check("p2_done", 160'(DONE), 160'(1));
    end

    // pass 3: reset during FETCH of segment 4, then restart
    SEG_READY = 1'b1;
    tick();
    begin_pass();
    for (int n = 0; n < 400 && !(SEG_IDX == 3'd4 && MEM_EN); n++) tick();
    check("p3_in_seg4_fetch", 160'({SEG_IDX, MEM_EN}), 160'({3'd4, 1'b1}));
    repeat (5) tick();
    RST_N = 1'b0;
    #1;
    check("mid_rst_busy", 160'(BUSY), 160'(0));
    check("mid_rst_mem_en", 160'(MEM_EN), 160'(0));
    check("mid_rst_addr", 160'(MEM_ADDR), 160'(0));
    check("mid_rst_idx", 160'(SEG_IDX), 160'(0));
    check("mid_rst_data", 160'(SEG_DATA), 160'(0));
    check("mid_rst_valid", 160'(SEG_VALID), 160'(0));
    check("mid_rst_state", 160'(dbg_state), 160'(0));
    tick();
    RST_N = 1'b1;
    repeat (4) tick();
    check("post_rst_idle", 160'(BUSY), 160'(0));
    exp_q.push_back(exp_seg(0));
    begin_pass();
    wait_valid("p3_valid");
    check("p3_valid_cycle", 160'(cyc), 160'(38));
    check("p3_idx", 160'(SEG_IDX), 160'(0));
    check("p3_data", 160'(SEG_DATA), 160'(exp_q.pop_front()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
